// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
//   ID/EX pipeline register in front of the ALU. It latches the decoded
//   operands and control from ID. Operands are resolved against later-stage
//   writers, either by forwarding or by interlocking. The register then drives
//   the ALU inputs (DataIn1/DataIn2/AluCtrl) and the values handed on to EX/MEM.
//
//   Build option: ALU_FWD_EN
//     defined   : MEM/WB -> EX forwarding muxes; stall only on load-use.
//     undefined : no forwarding; load_use_stall_o is a full RAW interlock
//                 against EX, MEM and WB writers.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   id_*_i                        decoded instruction from ID
//   id_flush_i                    kill the instruction entering EX
//   ex_hold_i                     downstream stall, freeze EX register
//   mem_*_i / wb_*_i              forwarding / interlock sources
//   load_use_stall_o              combinational; upstream holds PC and IF/ID
//   ex_*_o                        ALU operands/op and fields passed to EX/MEM
// -----------------------------------------------------------------------------
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [4:0]        id_shamt_i,
    input  logic [4:0]        id_alu_ctrl_i,
    input  logic              id_alu_src_i,
    input  logic              id_shift_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    input  logic              id_flush_i,
    input  logic              ex_hold_i,
    input  logic              mem_reg_write_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic [DATA_W-1:0] mem_result_i,
    input  logic              wb_reg_write_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [DATA_W-1:0] wb_result_i,
    output logic              load_use_stall_o,
    output logic              ex_valid_o,
    output logic [DATA_W-1:0] ex_data_in1_o,
    output logic [DATA_W-1:0] ex_data_in2_o,
    output logic [4:0]        ex_alu_ctrl_o,
    output logic [DATA_W-1:0] ex_store_data_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              ex_reg_write_o,
    output logic              ex_mem_read_o
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        shamt;
        logic [4:0]        alu_ctrl;
        logic              alu_src;
        logic              shift;
        logic              reg_write;
        logic              mem_read;
    } ex_reg_t;

    ex_reg_t ex_q, ex_d;

    logic [DATA_W-1:0] fwd_rs, fwd_rt;

`ifdef ALU_FWD_EN
    // MEM is the younger writer, so it wins over WB. Register 0 never forwards.
    always_comb begin
        fwd_rs = ex_q.rs_data;
        if (mem_reg_write_i && mem_rd_i != '0 && mem_rd_i == ex_q.rs)
            fwd_rs = mem_result_i;
        else if (wb_reg_write_i && wb_rd_i != '0 && wb_rd_i == ex_q.rs)
            fwd_rs = wb_result_i;
    end

    always_comb begin
        fwd_rt = ex_q.rt_data;
        if (mem_reg_write_i && mem_rd_i != '0 && mem_rd_i == ex_q.rt)
            fwd_rt = mem_result_i;
        else if (wb_reg_write_i && wb_rd_i != '0 && wb_rd_i == ex_q.rt)
            fwd_rt = wb_result_i;
    end

    // Only a load in EX cannot be forwarded in time; both sources are compared
    // even if the instruction does not read rt.
    assign load_use_stall_o = !rst_i && id_valid_i && ex_q.valid && ex_q.mem_read &&
                              (ex_q.rd != '0) &&
                              (ex_q.rd == id_rs_i || ex_q.rd == id_rt_i);
`else
    logic unused_results;
    assign unused_results = ^{mem_result_i, wb_result_i};

    assign fwd_rs = ex_q.rs_data;
    assign fwd_rt = ex_q.rt_data;

    // Without forwarding, any pending writer of a nonzero ID source interlocks.
    function automatic logic raw_hit(input logic [REG_AW-1:0] src);
        raw_hit = (src != '0) &&
                  ((ex_q.valid && ex_q.reg_write && ex_q.rd == src) ||
                   (mem_reg_write_i && mem_rd_i == src) ||
                   (wb_reg_write_i && wb_rd_i == src));
    endfunction

    assign load_use_stall_o = !rst_i && id_valid_i && (raw_hit(id_rs_i) || raw_hit(id_rt_i));
`endif

    always_comb begin
        ex_d = ex_q;
        if (id_flush_i) begin
            ex_d = '0;
        end else if (ex_hold_i) begin
            ex_d = ex_q;
        end else if (load_use_stall_o) begin
            ex_d = '0;
        end else begin
            ex_d.valid     = id_valid_i;
            ex_d.rs        = id_rs_i;
            ex_d.rt        = id_rt_i;
            ex_d.rd        = id_rd_i;
            ex_d.rs_data   = id_rs_data_i;
            ex_d.rt_data   = id_rt_data_i;
            ex_d.imm       = id_imm_i;
            ex_d.shamt     = id_shamt_i;
            // An empty ID slot becomes a bubble: no side effects downstream.
            ex_d.alu_ctrl  = id_valid_i ? id_alu_ctrl_i : '0;
            ex_d.alu_src   = id_valid_i & id_alu_src_i;
            ex_d.shift     = id_valid_i & id_shift_i;
            ex_d.reg_write = id_valid_i & id_reg_write_i;
            ex_d.mem_read  = id_valid_i & id_mem_read_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    // Shift amount sits at bits [10:6] of operand B, matching the ALU's shifter.
    logic [DATA_W-1:0] shamt_op;
    assign shamt_op = {{(DATA_W-11){1'b0}}, ex_q.shamt, 6'b0};

    assign ex_data_in1_o   = ex_q.shift ? fwd_rt : fwd_rs;
    assign ex_data_in2_o   = ex_q.shift ? shamt_op : (ex_q.alu_src ? ex_q.imm : fwd_rt);
    assign ex_store_data_o = fwd_rt;
    assign ex_alu_ctrl_o   = ex_q.alu_ctrl;
    assign ex_valid_o      = ex_q.valid;
    assign ex_rd_o         = ex_q.rd;
    assign ex_reg_write_o  = ex_q.reg_write;
    assign ex_mem_read_o   = ex_q.mem_read;

endmodule
